// File: rtl/adc_sample_timer_if.sv
`default_nettype none
// ============================================================================
// Module   : adc_sample_timer_if
// Purpose  : Channel-configuration handshake bundle for adc_sample_timer.
// Revision : 1.0 - initial release
// ============================================================================
interface adc_sample_timer_if #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 16
);
   localparam int c_CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic              cfg_valid;
   logic              cfg_ready;
   logic [c_CH_W-1:0] cfg_ch;
   logic [CNT_W-1:0]  cfg_div;
   logic [CNT_W-1:0]  cfg_high;
   logic [CNT_W-1:0]  cfg_phase;

   modport master (
      output cfg_valid, cfg_ch, cfg_div, cfg_high, cfg_phase,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid, cfg_ch, cfg_div, cfg_high, cfg_phase,
      output cfg_ready
   );
endinterface
`default_nettype wire

// File: rtl/adc_sample_timer.sv
`default_nettype none
// ============================================================================
// Module   : adc_sample_timer
// Purpose  : Multi-channel ADC sample timer: per-channel duty level and
//            period-start strobe with run-time divisor/high/phase config.
// Revision : 1.0 - initial release
// ============================================================================
module adc_sample_timer #(
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = 16,
   parameter int DEFAULT_DIV = 3000
) (
   input  wire logic              clk,
   input  wire logic              rst_n,
   input  wire logic              enable,
   input  wire logic              sync,
   adc_sample_timer_if.slave      cfg,
   output logic [NUM_CH-1:0]      clk_enable,
   output logic [NUM_CH-1:0]      sample_strobe
);
   localparam int                c_CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [c_CH_W:0]   c_NUM_CH = (c_CH_W + 1)'(NUM_CH);
   localparam logic [CNT_W-1:0]  c_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0]  c_TWO    = CNT_W'(2);

   logic              r_pend;
   logic [c_CH_W-1:0] r_pend_ch;
   logic [CNT_W-1:0]  r_pend_div;
   logic [CNT_W-1:0]  r_pend_high;
   logic [CNT_W-1:0]  r_pend_phase;

   logic              w_discard;
   logic              w_pend_ok;
   logic [NUM_CH-1:0] w_apply;
   logic [CNT_W-1:0]  w_cap_div;
   logic [CNT_W-1:0]  w_cap_phase;

   // Out-of-range values are clamped once, on capture into the slot.
   always_comb begin
      w_cap_div   = (cfg.cfg_div < c_TWO) ? c_TWO : cfg.cfg_div;
      w_cap_phase = (cfg.cfg_phase >= w_cap_div) ? (w_cap_div - c_ONE) : cfg.cfg_phase;
   end

   assign w_discard     = r_pend && ({1'b0, r_pend_ch} >= c_NUM_CH);
   assign w_pend_ok     = r_pend && !w_discard;
   assign cfg.cfg_ready = !r_pend;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend       <= 1'b0;
         r_pend_ch    <= '0;
         r_pend_div   <= '0;
         r_pend_high  <= '0;
         r_pend_phase <= '0;
      end else if (r_pend) begin
         if ((|w_apply) || w_discard)
            r_pend <= 1'b0;
      end else if (cfg.cfg_valid) begin
         r_pend       <= 1'b1;
         r_pend_ch    <= cfg.cfg_ch;
         r_pend_div   <= w_cap_div;
         r_pend_high  <= cfg.cfg_high;
         r_pend_phase <= w_cap_phase;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [CNT_W-1:0] r_count;
      logic [CNT_W-1:0] r_div;
      logic [CNT_W-1:0] r_high;
      logic [CNT_W-1:0] r_phase;
      logic             r_run;
      logic             r_ce;
      logic             r_st;
      logic             w_wrap;
      logic [CNT_W-1:0] w_div;
      logic [CNT_W-1:0] w_high;
      logic [CNT_W-1:0] w_phase;
      logic [CNT_W-1:0] w_next;

      // Wrap is judged against the period in progress, so a new divisor
      // only takes hold from the count==0 it is applied on.
      assign w_wrap     = r_run && (r_count == (r_div - c_ONE));
      assign w_apply[i] = w_pend_ok && (r_pend_ch == c_CH_W'(i)) &&
                          (!enable || !r_run || sync || w_wrap);

      assign w_div   = w_apply[i] ? r_pend_div   : r_div;
      assign w_high  = w_apply[i] ? r_pend_high  : r_high;
      assign w_phase = w_apply[i] ? r_pend_phase : r_phase;

      always_comb begin
         w_next = r_count + c_ONE;
         if (!enable || !r_run || sync)
            w_next = w_phase;
         else if (w_wrap)
            w_next = '0;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_count <= '0;
            r_div   <= CNT_W'(DEFAULT_DIV);
            r_high  <= CNT_W'(DEFAULT_DIV / 2);
            r_phase <= '0;
            r_run   <= 1'b0;
            r_ce    <= 1'b0;
            r_st    <= 1'b0;
         end else begin
            r_div   <= w_div;
            r_high  <= w_high;
            r_phase <= w_phase;
            r_count <= w_next;
            r_run   <= enable;
            r_ce    <= enable && (w_next < w_high);
            r_st    <= enable && (w_next == '0);
         end
      end

      assign clk_enable[i]    = r_ce;
      assign sample_strobe[i] = r_st;
   end
endmodule
`default_nettype wire

// File: tb/tb_adc_sample_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_sample_timer
// Purpose  : Self-checking bench: directed scenarios plus random traffic
//            compared every cycle against a behavioural channel model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_sample_timer;
   // Three channels so that a 2-bit cfg_ch can address a non-existent one.
   localparam int NUM_CH      = 3;
   localparam int CNT_W       = 16;
   localparam int DEFAULT_DIV = 3000;
   localparam int CH_W        = 2;

   logic              clk;
   logic              rst_n;
   logic              enable;
   logic              sync;
   logic [NUM_CH-1:0] clk_enable;
   logic [NUM_CH-1:0] sample_strobe;

   adc_sample_timer_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) cfg_bus ();

   adc_sample_timer #(
      .NUM_CH      (NUM_CH),
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable        (enable),
      .sync          (sync),
      .cfg           (cfg_bus),
      .clk_enable    (clk_enable),
      .sample_strobe (sample_strobe)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: each channel is a modulo-div counter.
   int                m_cnt  [NUM_CH];
   int                m_div  [NUM_CH];
   int                m_high [NUM_CH];
   int                m_phase[NUM_CH];
   bit                m_run  [NUM_CH];
   bit                m_pend;
   int                m_pch, m_pdiv, m_phigh, m_pphase;
   logic [NUM_CH-1:0] m_ce, m_st;

   task automatic model_reset();
      for (int i = 0; i < NUM_CH; i++) begin
         m_cnt[i] = 0; m_div[i] = DEFAULT_DIV; m_high[i] = DEFAULT_DIV / 2;
         m_phase[i] = 0; m_run[i] = 0;
      end
      m_pend = 0; m_ce = '0; m_st = '0;
   endtask

   task automatic model_step();
      int  tgt;
      bit  drop;
      int  old_div;
      tgt  = -1;
      drop = 0;
      if (m_pend) begin
         if (m_pch >= NUM_CH) drop = 1;
         else if (!enable || !m_run[m_pch] || sync ||
                  ((m_cnt[m_pch] + 1) % m_div[m_pch] == 0)) tgt = m_pch;
      end
      for (int i = 0; i < NUM_CH; i++) begin
         old_div = m_div[i];
         if (i == tgt) begin
            m_div[i] = m_pdiv; m_high[i] = m_phigh; m_phase[i] = m_pphase;
         end
         if (!enable) begin
            m_cnt[i] = m_phase[i]; m_run[i] = 0; m_ce[i] = 0; m_st[i] = 0;
         end else begin
            if (!m_run[i] || sync) m_cnt[i] = m_phase[i];
            else                   m_cnt[i] = (m_cnt[i] + 1) % old_div;
            m_run[i] = 1;
            m_ce[i]  = (m_cnt[i] < m_high[i]);
            m_st[i]  = (m_cnt[i] == 0);
         end
      end
      if (m_pend) begin
         if (tgt >= 0 || drop) m_pend = 0;
      end else if (cfg_bus.cfg_valid) begin
         m_pend   = 1;
         m_pch    = int'(cfg_bus.cfg_ch);
         m_pdiv   = (cfg_bus.cfg_div < 2) ? 2 : int'(cfg_bus.cfg_div);
         m_phigh  = int'(cfg_bus.cfg_high);
         m_pphase = (int'(cfg_bus.cfg_phase) >= m_pdiv) ? m_pdiv - 1 : int'(cfg_bus.cfg_phase);
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else        model_step();
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         chk("model_clk_enable", clk_enable, m_ce);
         chk("model_sample_strobe", sample_strobe, m_st);
         chk("model_cfg_ready", cfg_bus.cfg_ready, !m_pend);
      end
   end

   task automatic do_cfg(input int ch, input int d, input int h, input int p);
      cfg_bus.cfg_ch    = CH_W'(ch);
      cfg_bus.cfg_div   = CNT_W'(d);
      cfg_bus.cfg_high  = CNT_W'(h);
      cfg_bus.cfg_phase = CNT_W'(p);
      cfg_bus.cfg_valid = 1'b1;
      @(negedge clk);
      cfg_bus.cfg_valid = 1'b0;
      chk("cfg_ready_busy", cfg_bus.cfg_ready, 1'b0);
      @(negedge clk);
      chk("cfg_ready_back", cfg_bus.cfg_ready, 1'b1);
   endtask

   initial begin
      int ce_hi;
      rst_n = 1'b0; enable = 1'b0; sync = 1'b0;
      cfg_bus.cfg_valid = 1'b0; cfg_bus.cfg_ch = '0;
      cfg_bus.cfg_div = '0; cfg_bus.cfg_high = '0; cfg_bus.cfg_phase = '0;
      repeat (3) @(negedge clk);
      chk("reset_clk_enable", clk_enable, 0);
      chk("reset_strobe", sample_strobe, 0);
      chk("reset_cfg_ready", cfg_bus.cfg_ready, 1);
      rst_n = 1'b1;
      @(negedge clk);

      // Defaults plus a 750-cycle phase on ch1.
      do_cfg(1, 3000, 1500, 750);
      enable = 1'b1;
      ce_hi  = 0;
      for (int k = 1; k <= 6101; k++) begin
         @(negedge clk);
         if (k <= 3000) ce_hi += int'(clk_enable[0]);
         if (k == 1)    begin chk("start_strobe", sample_strobe, 3'b101);
                              chk("start_ce0", clk_enable[0], 1); end
         if (k == 1500) chk("duty_last_high", clk_enable[0], 1);
         if (k == 1501) chk("duty_first_low", clk_enable[0], 0);
         if (k == 2250) chk("ch1_before_strobe", sample_strobe[1], 0);
         if (k == 2251) chk("ch1_phase_strobe", sample_strobe[1], 1);
         if (k == 3000) chk("ch0_no_early_strobe", sample_strobe[0], 0);
         if (k == 3001) chk("ch0_period_strobe", sample_strobe[0], 1);
      end
      chk("ch0_high_cycles", ce_hi, 1500);

      // ch0 is at count 100: reconfigure while running.
      cfg_bus.cfg_ch = 2'd0; cfg_bus.cfg_div = 16'd10;
      cfg_bus.cfg_high = 16'd3; cfg_bus.cfg_phase = 16'd4;
      cfg_bus.cfg_valid = 1'b1;
      for (int k = 6102; k <= 9017; k++) begin
         @(negedge clk);
         if (k == 6102) begin cfg_bus.cfg_valid = 1'b0;
                              chk("run_cfg_ready_low", cfg_bus.cfg_ready, 0); end
         if (k == 9000) begin chk("run_cfg_ready_wait", cfg_bus.cfg_ready, 0);
                              chk("old_period_intact", sample_strobe[0], 0); end
         if (k == 9001) begin chk("run_cfg_ready_back", cfg_bus.cfg_ready, 1);
                              chk("wrap_strobe", sample_strobe[0], 1); end
         if (k == 9003) chk("new_high_last", clk_enable[0], 1);
         if (k == 9004) chk("new_high_done", clk_enable[0], 0);
         if (k == 9010) sync = 1'b1;
         if (k == 9011) begin sync = 1'b0;
                              chk("sync_strobe", sample_strobe, 3'b100);
                              chk("sync_ce", clk_enable, 3'b110); end
         if (k == 9017) chk("post_sync_strobe", sample_strobe[0], 1);
      end

      // Edge values, loaded while disabled.
      enable = 1'b0;
      repeat (2) @(negedge clk);
      do_cfg(2, 1, 1, 0);
      do_cfg(1, 10, 20, 0);
      do_cfg(0, 5, 0, 0);
      do_cfg(3, 7, 2, 1);
      enable = 1'b1;
      for (int j = 1; j <= 40; j++) begin
         @(negedge clk);
         chk("edge_ce", clk_enable, {1'(j % 2 == 1), 1'b1, 1'b0});
         chk("edge_strobe", sample_strobe,
             {1'(j % 2 == 1), 1'(j % 10 == 1), 1'(j % 5 == 1)});
      end

      // Asynchronous reset with a config pending and outputs high.
      cfg_bus.cfg_ch = 2'd1; cfg_bus.cfg_div = 16'd50;
      cfg_bus.cfg_high = 16'd5; cfg_bus.cfg_phase = 16'd0;
      cfg_bus.cfg_valid = 1'b1;
      @(negedge clk);
      cfg_bus.cfg_valid = 1'b0;
      chk("pend_before_reset", cfg_bus.cfg_ready, 0);
      chk("ce_before_reset", clk_enable[1], 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_ce", clk_enable, 0);
      chk("async_strobe", sample_strobe, 0);
      chk("async_cfg_ready", cfg_bus.cfg_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("restart_strobe", sample_strobe, 3'b111);
      chk("restart_ce", clk_enable, 3'b111);
      repeat (5) @(negedge clk);
      chk("default_div_back", sample_strobe, 0);

      // Random traffic, checked by the model every cycle.
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         if ($urandom_range(0, 99) == 0) enable = ~enable;
         sync              = ($urandom_range(0, 39) == 0);
         cfg_bus.cfg_valid = ($urandom_range(0, 3) == 0);
         cfg_bus.cfg_ch    = CH_W'($urandom_range(0, 3));
         cfg_bus.cfg_div   = CNT_W'($urandom_range(0, 24));
         cfg_bus.cfg_high  = CNT_W'($urandom_range(0, 26));
         cfg_bus.cfg_phase = CNT_W'($urandom_range(0, 26));
      end
      enable = 1'b0; sync = 1'b0; cfg_bus.cfg_valid = 1'b0;
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
